// File: rtl/call_stack_pkg.sv
// Shared types and defaults for the call/return stack sequencer.
// Imported by the arbiter and the controller.
package call_stack_pkg;

  localparam int AW_DEF    = 11;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_IRQ  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_RETI = 3'd4
  } op_t;

  function automatic logic is_push_op(op_t op);
    return (op == OP_IRQ) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/call_stack_arb.sv
// Fixed-priority request selector: IRQ > CALL > RET > RETI.
// IRQ is blocked inside an ISR; RETI only counts inside one.
module call_stack_arb
  import call_stack_pkg::*;
(
  input  logic irq_req,
  input  logic call_req,
  input  logic ret_req,
  input  logic reti_req,
  input  logic in_isr,
  output op_t  op
);

  always_comb begin
    op = OP_NONE;
    priority case (1'b1)
      irq_req && !in_isr: op = OP_IRQ;
      call_req:           op = OP_CALL;
      ret_req:            op = OP_RET;
      reti_req && in_isr: op = OP_RETI;
      default:            op = OP_NONE;
    endcase
  end

endmodule

// File: rtl/call_stack_ctrl.sv
// Sequencer in front of the return-address stack: grants one
// CALL/RET/IRQ/RETI at a time, drives the stack, returns next PC.
module call_stack_ctrl
  import call_stack_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          call_req,
  input  logic          ret_req,
  input  logic          irq_req,
  input  logic          reti_req,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] call_target,
  input  logic [AW-1:0] irq_vector,
  input  logic          err_clr,
  input  logic [AW-1:0] stk_dout,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [AW-1:0] stk_din,
  output logic          ack,
  output logic          pc_load,
  output logic [AW-1:0] pc_next,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          in_isr,
  output logic          ovf_err,
  output logic          unf_err,
  output logic          busy
);

  state_t        state;
  op_t           op_sel;
  op_t           op_q;
  logic          err_q;
  logic [AW-1:0] tgt_q;

  call_stack_arb u_arb (
    .irq_req  (irq_req),
    .call_req (call_req),
    .ret_req  (ret_req),
    .reti_req (reti_req),
    .in_isr   (in_isr),
    .op       (op_sel)
  );

  assign full  = (depth == CW'(DEPTH));
  assign empty = (depth == '0);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_NONE;
      err_q    <= 1'b0;
      tgt_q    <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_din  <= '0;
      ack      <= 1'b0;
      pc_load  <= 1'b0;
      pc_next  <= '0;
      depth    <= '0;
      in_isr   <= 1'b0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else begin
      // clear first so a same-cycle error set below takes priority
      if (err_clr) begin
        ovf_err <= 1'b0;
        unf_err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          ack     <= 1'b0;
          pc_load <= 1'b0;
          if (op_sel != OP_NONE) begin
            state <= EXEC;
            op_q  <= op_sel;
            tgt_q <= (op_sel == OP_IRQ) ? irq_vector : call_target;
            if (is_push_op(op_sel)) begin
              err_q <= full;
              if (!full) begin
                stk_push <= 1'b1;
                stk_din  <= (op_sel == OP_CALL) ?
                            pc_in + AW'(1) : pc_in;
              end
            end else begin
              err_q <= empty;
              if (!empty) stk_pop <= 1'b1;
            end
          end
        end
        EXEC: begin
          stk_push <= 1'b0;
          stk_pop  <= 1'b0;
          ack      <= 1'b1;
          state    <= DONE;
          if (err_q) begin
            if (is_push_op(op_q)) ovf_err <= 1'b1;
            else                  unf_err <= 1'b1;
          end else begin
            pc_load <= 1'b1;
            if (is_push_op(op_q)) begin
              pc_next <= tgt_q;
              depth   <= depth + CW'(1);
              if (op_q == OP_IRQ) in_isr <= 1'b1;
            end else begin
              // top of stack is still valid until this edge pops it
              pc_next <= stk_dout;
              depth   <= depth - CW'(1);
              if (op_q == OP_RETI) in_isr <= 1'b0;
            end
          end
        end
        DONE: begin
          ack     <= 1'b0;
          pc_load <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Scoreboard bench for call_stack_ctrl with a behavioural
// 16-entry return-address stack attached.
module tb_call_stack_ctrl;

  localparam int O_CALL = 0;
  localparam int O_IRQ  = 1;
  localparam int O_RET  = 2;
  localparam int O_RETI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        call_req, ret_req, irq_req, reti_req;
  logic [10:0] pc_in, call_target, irq_vector;
  logic        err_clr;
  logic [10:0] stk_dout;
  logic        stk_push, stk_pop;
  logic [10:0] stk_din;
  logic        ack, pc_load;
  logic [10:0] pc_next;
  logic [4:0]  depth;
  logic        full, empty, in_isr;
  logic        ovf_err, unf_err, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        load;
    logic [10:0] pc;
    logic [4:0]  dep;
    logic        push;
    logic        pop;
    logic [10:0] din;
    logic        isr;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [10:0] m_stk[$];
  int          m_depth;
  logic        m_isr, m_ovf, m_unf;

  logic [10:0] mem [0:15];
  logic [3:0]  sp;

  always #5 clk = ~clk;

  assign stk_dout = mem[sp];

  always @(posedge clk) begin
    if (reset) sp <= 4'd15;
    else if (stk_push) begin
      mem[sp + 4'd1] <= stk_din;
      sp <= sp + 4'd1;
    end else if (stk_pop) sp <= sp - 4'd1;
  end

  call_stack_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .call_req    (call_req),
    .ret_req     (ret_req),
    .irq_req     (irq_req),
    .reti_req    (reti_req),
    .pc_in       (pc_in),
    .call_target (call_target),
    .irq_vector  (irq_vector),
    .err_clr     (err_clr),
    .stk_dout    (stk_dout),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_din     (stk_din),
    .ack         (ack),
    .pc_load     (pc_load),
    .pc_next     (pc_next),
    .depth       (depth),
    .full        (full),
    .empty       (empty),
    .in_isr      (in_isr),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err),
    .busy        (busy)
  );

  task automatic set_req(input int op, input logic v);
    case (op)
      O_CALL:  call_req = v;
      O_IRQ:   irq_req  = v;
      O_RET:   ret_req  = v;
      default: reti_req = v;
    endcase
  endtask

  task automatic run_op(input int op,
                        input logic [10:0] pc,
                        input logic [10:0] tgt);
    exp_t e;
    int n, push_k, pop_k, ack_k, npush, npop;
    logic [10:0] din_seen;
    e.load = 1'b0; e.pc = '0; e.push = 1'b0;
    e.pop = 1'b0;  e.din = '0;
    if (op == O_CALL || op == O_IRQ) begin
      if (m_depth == 16) m_ovf = 1'b1;
      else begin
        e.push = 1'b1;
        e.din  = (op == O_CALL) ? pc + 11'd1 : pc;
        m_stk.push_back(e.din);
        m_depth++;
        e.load = 1'b1;
        e.pc   = tgt;
        if (op == O_IRQ) m_isr = 1'b1;
      end
    end else begin
      if (m_depth == 0) m_unf = 1'b1;
      else begin
        e.pop  = 1'b1;
        e.pc   = m_stk.pop_back();
        m_depth--;
        e.load = 1'b1;
        if (op == O_RETI) m_isr = 1'b0;
      end
    end
    e.dep = 5'(m_depth);
    e.isr = m_isr;
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);

    n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    pc_in = pc; call_target = tgt; irq_vector = tgt;
    set_req(op, 1'b1);
    push_k = 0; pop_k = 0; ack_k = 0;
    npush = 0; npop = 0; din_seen = '0;
    for (int k = 1; k <= 8 && ack_k == 0; k++) begin
      @(negedge clk);
      checks++;
      if (stk_push && stk_pop) begin
        failures++;
        $display("FAIL both_strobes op=%0d push=1 pop=1", op);
      end
      if (stk_push) begin npush++; push_k = k; din_seen = stk_din; end
      if (stk_pop)  begin npop++;  pop_k = k; end
      if (ack) ack_k = k;
    end
    e = sb.pop_front();
    checks++;
    if (ack_k !== 2) begin
      failures++;
      $display("FAIL ack_latency op=%0d got=%0d want=2", op, ack_k);
    end
    checks++;
    if (npush !== int'(e.push) || npop !== int'(e.pop)) begin
      failures++;
      $display("FAIL strobes op=%0d push=%0d pop=%0d want %0d/%0d",
               op, npush, npop, e.push, e.pop);
    end
    if (e.push || e.pop) begin
      checks++;
      if ((e.push ? push_k : pop_k) !== 1) begin
        failures++;
        $display("FAIL strobe_cycle op=%0d got=%0d want=1",
                 op, e.push ? push_k : pop_k);
      end
    end
    if (e.push) begin
      checks++;
      if (din_seen !== e.din) begin
        failures++;
        $display("FAIL stk_din op=%0d got=%h want=%h",
                 op, din_seen, e.din);
      end
    end
    checks++;
    if (pc_load !== e.load) begin
      failures++;
      $display("FAIL pc_load op=%0d got=%b want=%b", op, pc_load, e.load);
    end
    if (e.load) begin
      checks++;
      if (pc_next !== e.pc) begin
        failures++;
        $display("FAIL pc_next op=%0d got=%h want=%h", op, pc_next, e.pc);
      end
    end
    checks++;
    if (depth !== e.dep || in_isr !== e.isr ||
        ovf_err !== e.ovf || unf_err !== e.unf) begin
      failures++;
      $display("FAIL status op=%0d dep=%0d isr=%b ovf=%b unf=%b want %0d %b %b %b",
               op, depth, in_isr, ovf_err, unf_err,
               e.dep, e.isr, e.ovf, e.unf);
    end
    set_req(op, 1'b0);
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || pc_load !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width op=%0d ack=%b pc_load=%b", op, ack, pc_load);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_depth = 0; m_isr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_stk.delete();
  endtask

  task automatic test_reset();
    call_req = 0; ret_req = 0; irq_req = 0; reti_req = 0;
    err_clr = 0; pc_in = '0; call_target = '0; irq_vector = '0;
    apply_reset();
    checks++;
    if (stk_push !== 0 || stk_pop !== 0 || ack !== 0 || pc_load !== 0) begin
      failures++;
      $display("FAIL reset_strobes push=%b pop=%b ack=%b load=%b",
               stk_push, stk_pop, ack, pc_load);
    end
    checks++;
    if (pc_next !== 11'd0 || stk_din !== 11'd0) begin
      failures++;
      $display("FAIL reset_data pc_next=%h din=%h want 0",
               pc_next, stk_din);
    end
    checks++;
    if (depth !== 5'd0 || empty !== 1 || full !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL reset_depth dep=%0d empty=%b full=%b busy=%b",
               depth, empty, full, busy);
    end
    checks++;
    if (in_isr !== 0 || ovf_err !== 0 || unf_err !== 0) begin
      failures++;
      $display("FAIL reset_flags isr=%b ovf=%b unf=%b",
               in_isr, ovf_err, unf_err);
    end
  endtask

  task automatic test_call_ret();
    run_op(O_CALL, 11'h010, 11'h200);
    run_op(O_RET, 11'h000, 11'h000);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_after_ret got=%b want=1", empty);
    end
  endtask

  task automatic test_irq_priority();
    int seen;
    call_req = 1'b1;
    run_op(O_IRQ, 11'h123, 11'h7F0);
    run_op(O_CALL, 11'h123, 11'h300);
    irq_req = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack || stk_push) seen++;
    end
    irq_req = 1'b0;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL nested_irq got=%0d events want=0", seen);
    end
    run_op(O_RET, 11'h000, 11'h000);
    run_op(O_RETI, 11'h000, 11'h000);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++)
      run_op(O_CALL, 11'(i * 16 + 5), 11'(i + 1));
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL full got=%b want=1", full);
    end
    run_op(O_CALL, 11'h400, 11'h401);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clr ovf got=%b want=0", ovf_err);
    end
  endtask

  task automatic test_underflow();
    int seen;
    for (int i = 0; i < 16; i++)
      run_op(O_RET, 11'h000, 11'h000);
    run_op(O_RET, 11'h000, 11'h000);
    seen = 0;
    reti_req = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ack || stk_pop || busy) seen++;
    end
    reti_req = 1'b0;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reti_outside_isr got=%0d events want=0", seen);
    end
  endtask

  task automatic test_wrap_and_reset();
    run_op(O_CALL, 11'h7FF, 11'h055);
    @(negedge clk);
    call_req = 1'b1;
    pc_in = 11'h020;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    call_req = 1'b0;
    m_depth = 0; m_isr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_stk.delete();
    checks++;
    if (depth !== 5'd0 || busy !== 0 || ack !== 0 ||
        pc_load !== 0 || stk_push !== 0) begin
      failures++;
      $display("FAIL reset_mid dep=%0d busy=%b ack=%b load=%b push=%b",
               depth, busy, ack, pc_load, stk_push);
    end
    run_op(O_CALL, 11'h030, 11'h100);
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_irq_priority();
    test_overflow();
    test_underflow();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
